// File: rtl/regfile_wb_arbiter.sv
// Two-requester round-robin write-back arbiter feeding one register-file
// write port. Index 0 is accepted but never written so x0 reads as zero.
module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  b_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [15:0]           wr_count,
  output logic                  last_grant
);

  logic                  grant_a;
  logic                  grant_b;
  logic                  wr_hit;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  // Grant decision: single valid requester wins outright, contention goes
  // to whoever was not granted last; nothing is granted during hold or reset.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst && !hold) begin
      if (a_valid && b_valid) begin
        grant_a = last_grant;
        grant_b = !last_grant;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Select the granted payload; a grant to index 0 is consumed without a write.
  always_comb begin
    sel_addr = a_addr;
    sel_data = a_data;
    wr_hit   = 1'b0;
    if (grant_a) begin
      wr_hit = (a_addr != '0);
    end else if (grant_b) begin
      sel_addr = b_addr;
      sel_data = b_data;
      wr_hit   = (b_addr != '0);
    end
  end

  // Registered write port, write counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen     <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      wr_count   <= 16'd0;
      last_grant <= 1'b1;
    end else begin
      rf_wen <= wr_hit;
      if (wr_hit) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
        wr_count <= wr_count + 16'd1;
      end
      if (grant_a) begin
        last_grant <= 1'b0;
      end else if (grant_b) begin
        last_grant <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table,
// hand-written multi-cycle sequences, counter wrap and a randomized run
// against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst, hold;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic          rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [15:0]   wr_count;
  logic          last_grant;

  int total = 0;
  int bad   = 0;
  logic obs_ar, obs_br;

  logic [DW-1:0] model_rf [32];
  logic [DW-1:0] seen_rf  [32];

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wr_count(wr_count), .last_grant(last_grant)
  );

  typedef struct {
    logic          r, h;
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          bv;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    logic          ar, br, wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [15:0]   cnt;
    logic          lg;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One clock: apply inputs, sample ready before the edge, then sample
  // registered outputs 1 time unit after the edge.
  task automatic step(input logic r, input logic h,
                      input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    rst = r; hold = h;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    obs_ar = a_ready;
    obs_br = b_ready;
    @(posedge clk);
    #1;
    if (rf_wen === 1'b1) seen_rf[rf_waddr] = rf_wdata;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Randomized run: requesters keep their request stable until accepted.
  task automatic random_run(input int n);
    logic          m_lg, m_wen;
    logic [15:0]   m_cnt;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic          ra_v, rb_v, r, h, ea, eb;
    logic [AW-1:0] ra_a, rb_a;
    logic [DW-1:0] ra_d, rb_d;
    do_reset();
    m_lg = 1'b1; m_wen = 1'b0; m_cnt = 16'd0; m_waddr = '0; m_wdata = '0;
    ra_v = 1'b0; rb_v = 1'b0; ra_a = '0; rb_a = '0; ra_d = '0; rb_d = '0;
    for (int k = 0; k < 32; k++) begin
      model_rf[k] = '0;
      seen_rf[k]  = '0;
    end
    for (int i = 0; i < n; i++) begin
      if (!ra_v) begin
        ra_v = ($urandom_range(0, 9) < 6);
        ra_a = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(0, 31));
        ra_d = {$urandom, $urandom};
      end
      if (!rb_v) begin
        rb_v = ($urandom_range(0, 9) < 6);
        rb_a = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(0, 31));
        rb_d = {$urandom, $urandom};
      end
      r = ($urandom_range(0, 49) == 0);
      h = ($urandom_range(0, 4) == 0);
      ea = 1'b0; eb = 1'b0;
      if (!r && !h) begin
        if (ra_v && rb_v) begin
          if (m_lg) ea = 1'b1; else eb = 1'b1;
        end else begin
          ea = ra_v; eb = rb_v;
        end
      end
      step(r, h, ra_v, ra_a, ra_d, rb_v, rb_a, rb_d);
      chk("rnd_a_ready", DW'(obs_ar), DW'(ea));
      chk("rnd_b_ready", DW'(obs_br), DW'(eb));
      if (r) begin
        m_lg = 1'b1; m_wen = 1'b0; m_cnt = 16'd0; m_waddr = '0; m_wdata = '0;
      end else begin
        m_wen = 1'b0;
        if (ea) begin
          m_lg = 1'b0;
          if (ra_a != 0) begin
            m_wen = 1'b1; m_waddr = ra_a; m_wdata = ra_d; m_cnt = m_cnt + 16'd1;
            model_rf[ra_a] = ra_d;
          end
          ra_v = 1'b0;
        end
        if (eb) begin
          m_lg = 1'b1;
          if (rb_a != 0) begin
            m_wen = 1'b1; m_waddr = rb_a; m_wdata = rb_d; m_cnt = m_cnt + 16'd1;
            model_rf[rb_a] = rb_d;
          end
          rb_v = 1'b0;
        end
      end
      chk("rnd_rf_wen", DW'(rf_wen), DW'(m_wen));
      chk("rnd_rf_waddr", DW'(rf_waddr), DW'(m_waddr));
      chk("rnd_rf_wdata", rf_wdata, m_wdata);
      chk("rnd_wr_count", DW'(wr_count), DW'(m_cnt));
      chk("rnd_last_grant", DW'(last_grant), DW'(m_lg));
    end
    for (int k = 0; k < 32; k++) chk($sformatf("rnd_rf_content[%0d]", k), seen_rf[k], model_rf[k]);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;

    //             r  h  av aa  ad         bv ba  bd        ar br wen waddr wdata      cnt  lg
    vec[0]  = '{1'b0,1'b0,1'b1,5'd3,64'hAA,  1'b0,5'd0,64'h0,   1'b1,1'b0,1'b1,5'd3, 64'hAA,   16'd1,1'b0};
    vec[1]  = '{1'b0,1'b0,1'b0,5'd0,64'h0,   1'b0,5'd0,64'h0,   1'b0,1'b0,1'b0,5'd3, 64'hAA,   16'd1,1'b0};
    vec[2]  = '{1'b0,1'b0,1'b1,5'd5,64'h11,  1'b1,5'd5,64'h22,  1'b0,1'b1,1'b1,5'd5, 64'h22,   16'd2,1'b1};
    vec[3]  = '{1'b0,1'b0,1'b1,5'd5,64'h11,  1'b1,5'd5,64'h22,  1'b1,1'b0,1'b1,5'd5, 64'h11,   16'd3,1'b0};
    vec[4]  = '{1'b0,1'b0,1'b1,5'd0,64'hFF,  1'b0,5'd0,64'h0,   1'b1,1'b0,1'b0,5'd5, 64'h11,   16'd3,1'b0};
    vec[5]  = '{1'b0,1'b1,1'b1,5'd1,64'h1,   1'b1,5'd2,64'h2,   1'b0,1'b0,1'b0,5'd5, 64'h11,   16'd3,1'b0};
    vec[6]  = '{1'b0,1'b0,1'b0,5'd0,64'h0,   1'b1,5'd31,64'hDEAD,1'b0,1'b1,1'b1,5'd31,64'hDEAD, 16'd4,1'b1};
    vec[7]  = '{1'b0,1'b0,1'b1,5'd0,64'hBAD, 1'b1,5'd6,64'h66,  1'b1,1'b0,1'b0,5'd31,64'hDEAD, 16'd4,1'b0};
    vec[8]  = '{1'b0,1'b0,1'b1,5'd7,64'h77,  1'b1,5'd9,64'h99,  1'b0,1'b1,1'b1,5'd9, 64'h99,   16'd5,1'b1};
    vec[9]  = '{1'b1,1'b0,1'b1,5'd7,64'h77,  1'b1,5'd4,64'h44,  1'b0,1'b0,1'b0,5'd0, 64'h0,    16'd0,1'b1};
    vec[10] = '{1'b0,1'b0,1'b1,5'd2,64'h1234,1'b1,5'd4,64'h5678,1'b1,1'b0,1'b1,5'd2, 64'h1234, 16'd1,1'b0};

    do_reset();
    chk("reset_rf_wen", DW'(rf_wen), '0);
    chk("reset_rf_waddr", DW'(rf_waddr), '0);
    chk("reset_rf_wdata", rf_wdata, '0);
    chk("reset_wr_count", DW'(wr_count), '0);
    chk("reset_last_grant", DW'(last_grant), 64'd1);

    for (int i = 0; i < 11; i++) begin
      step(vec[i].r, vec[i].h, vec[i].av, vec[i].aa, vec[i].ad, vec[i].bv, vec[i].ba, vec[i].bd);
      chk($sformatf("vec%0d_a_ready", i), DW'(obs_ar), DW'(vec[i].ar));
      chk($sformatf("vec%0d_b_ready", i), DW'(obs_br), DW'(vec[i].br));
      chk($sformatf("vec%0d_rf_wen", i), DW'(rf_wen), DW'(vec[i].wen));
      chk($sformatf("vec%0d_rf_waddr", i), DW'(rf_waddr), DW'(vec[i].waddr));
      chk($sformatf("vec%0d_rf_wdata", i), rf_wdata, vec[i].wdata);
      chk($sformatf("vec%0d_wr_count", i), DW'(wr_count), DW'(vec[i].cnt));
      chk($sformatf("vec%0d_last_grant", i), DW'(last_grant), DW'(vec[i].lg));
    end

    // Same-index contention from reset: A first, then B retries and wins.
    do_reset();
    step(1'b0, 1'b0, 1'b1, 5'd5, 64'h11, 1'b1, 5'd5, 64'h22);
    chk("same_idx_c0_a_ready", DW'(obs_ar), 64'd1);
    chk("same_idx_c0_wdata", rf_wdata, 64'h11);
    step(1'b0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1, 5'd5, 64'h22);
    chk("same_idx_c1_b_ready", DW'(obs_br), 64'd1);
    chk("same_idx_c1_wen", DW'(rf_wen), 64'd1);
    chk("same_idx_c1_wdata", rf_wdata, 64'h22);
    chk("same_idx_last_grant", DW'(last_grant), 64'd1);
    chk("same_idx_wr_count", DW'(wr_count), 64'd2);
    idle();
    chk("same_idx_wen_drop", DW'(rf_wen), '0);

    // Continuous contention: strict alternation at full throughput.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1, 5'd1, DW'(100 + i), 1'b1, 5'd2, DW'(200 + i));
      chk($sformatf("alt%0d_a_ready", i), DW'(obs_ar), DW'(i % 2 == 0));
      chk($sformatf("alt%0d_b_ready", i), DW'(obs_br), DW'(i % 2 == 1));
      chk($sformatf("alt%0d_wen", i), DW'(rf_wen), 64'd1);
      chk($sformatf("alt%0d_wdata", i), rf_wdata, (i % 2 == 0) ? DW'(100 + i) : DW'(200 + i));
    end
    chk("alt_wr_count", DW'(wr_count), 64'd6);

    // Hold blocks both requesters; A wins on release.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 5'd8, 64'h8, 1'b1, 5'd9, 64'h9);
      chk($sformatf("hold%0d_ready", i), DW'({obs_ar, obs_br}), '0);
      chk($sformatf("hold%0d_wen", i), DW'(rf_wen), '0);
    end
    step(1'b0, 1'b0, 1'b1, 5'd8, 64'h8, 1'b1, 5'd9, 64'h9);
    chk("hold_release_a_ready", DW'(obs_ar), 64'd1);
    chk("hold_release_b_ready", DW'(obs_br), '0);
    chk("hold_release_waddr", DW'(rf_waddr), 64'd8);

    // Counter wrap.
    do_reset();
    for (int i = 0; i < 65535; i++) step(1'b0, 1'b0, 1'b1, 5'd1, DW'(i), 1'b0, '0, '0);
    chk("wrap_preload", DW'(wr_count), 64'hFFFF);
    step(1'b0, 1'b0, 1'b1, 5'd1, 64'h5A, 1'b0, '0, '0);
    chk("wrap_to_zero", DW'(wr_count), '0);
    chk("wrap_wen", DW'(rf_wen), 64'd1);

    random_run(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
